maincontroller: RTL and testbench

MAINCONTROLLER -- requirements
Module: maincontroller

---
 rtl/maincontroller_pkg.sv | 62 ++++++
 rtl/maincontroller_key_edge.sv | 44 ++++
 rtl/maincontroller.sv | 101 ++++++++++
 tb/tb_maincontroller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/maincontroller_pkg.sv
// Shared constants and decode helpers for the coin-operated vending controller.
package maincontroller_pkg;

    localparam int BAL_W = 7;
    localparam logic [BAL_W-1:0] BAL_MAX = 7'd99;

    localparam logic [BAL_W-1:0] COIN_PENNY   = 7'd1;
    localparam logic [BAL_W-1:0] COIN_NICKEL  = 7'd5;
    localparam logic [BAL_W-1:0] COIN_DIME    = 7'd10;
    localparam logic [BAL_W-1:0] COIN_QUARTER = 7'd25;

    localparam logic [BAL_W-1:0] PRICE_0 = 7'd25;
    localparam logic [BAL_W-1:0] PRICE_1 = 7'd50;
    localparam logic [BAL_W-1:0] PRICE_2 = 7'd75;
    localparam logic [BAL_W-1:0] PRICE_3 = 7'd99;

    // Highest set bit of the coin switches selects the coin; zero means no coin.
    function automatic logic [BAL_W-1:0] coin_value(input logic [3:0] sel);
        logic [BAL_W-1:0] val;
        if (sel[3]) begin
            val = COIN_QUARTER;
        end else if (sel[2]) begin
            val = COIN_DIME;
        end else if (sel[1]) begin
            val = COIN_NICKEL;
        end else if (sel[0]) begin
            val = COIN_PENNY;
        end else begin
            val = 7'd0;
        end
        return val;
    endfunction

    function automatic logic [3:0] coin_onehot(input logic [3:0] sel);
        logic [3:0] oh;
        if (sel[3]) begin
            oh = 4'b1000;
        end else if (sel[2]) begin
            oh = 4'b0100;
        end else if (sel[1]) begin
            oh = 4'b0010;
        end else if (sel[0]) begin
            oh = 4'b0001;
        end else begin
            oh = 4'b0000;
        end
        return oh;
    endfunction

    function automatic logic [BAL_W-1:0] price_value(input logic [1:0] sel);
        logic [BAL_W-1:0] val;
        case (sel)
            2'b00:   val = PRICE_0;
            2'b01:   val = PRICE_1;
            2'b10:   val = PRICE_2;
            2'b11:   val = PRICE_3;
            default: val = PRICE_3;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/maincontroller_key_edge.sv
// Two-flop synchronizer plus falling-edge detector for one active-low pushbutton.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic [1:0] fill_q,  fill_d;
    logic       armed_q, armed_d;

    // Next-state: fill_q marks when sync2 reflects the real pin; arming waits for a released level
    // so a button held through reset never fires.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & sync2_q);
    end

    // State registers with synchronous reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign press = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/maincontroller.sv
// Vending controller: coin deposit accumulation, vend against a selected price, status lamps.
module maincontroller
    import maincontroller_pkg::*;
(
    input  logic             MAX10_CLK1_50,
    input  logic [9:0]       SW,
    input  logic [1:0]       KEY,
    output logic [BAL_W-1:0] balance_c,
    output logic [9:0]       LEDR
);

    logic             rst_s;
    logic             dep_ev_s;
    logic             vend_ev_s;
    logic [BAL_W-1:0] coin_s;
    logic [BAL_W-1:0] price_s;
    logic [BAL_W:0]   sum_s;
    logic             unused_sw_s;

    logic [BAL_W-1:0] balance_q,   balance_d;
    logic [3:0]       coin_led_q,  coin_led_d;
    logic [1:0]       price_sel_q;
    logic             reject_q,    reject_d;
    logic             insuf_q,     insuf_d;
    logic             vend_q,      vend_d;

    assign rst_s       = SW[9];
    assign unused_sw_s = ^SW[8:6];

    key_edge u_key_dep (
        .clk   (MAX10_CLK1_50),
        .rst   (rst_s),
        .key_n (KEY[0]),
        .press (dep_ev_s)
    );

    key_edge u_key_vend (
        .clk   (MAX10_CLK1_50),
        .rst   (rst_s),
        .key_n (KEY[1]),
        .press (vend_ev_s)
    );

    assign coin_s  = coin_value(SW[3:0]);
    assign price_s = price_value(SW[5:4]);
    assign sum_s   = {1'b0, balance_q} + {1'b0, coin_s};

    // Press handling: vend wins over a same-cycle deposit; an accepted press clears all flags first.
    always_comb begin
        balance_d  = balance_q;
        coin_led_d = coin_led_q;
        reject_d   = reject_q;
        insuf_d    = insuf_q;
        vend_d     = vend_q;
        if (vend_ev_s) begin
            reject_d = 1'b0;
            if (balance_q >= price_s) begin
                balance_d = balance_q - price_s;
                vend_d    = 1'b1;
                insuf_d   = 1'b0;
            end else begin
                vend_d    = 1'b0;
                insuf_d   = 1'b1;
            end
        end else if (dep_ev_s && (coin_s != 7'd0)) begin
            insuf_d = 1'b0;
            vend_d  = 1'b0;
            if (sum_s <= {1'b0, BAL_MAX}) begin
                balance_d  = sum_s[BAL_W-1:0];
                coin_led_d = coin_onehot(SW[3:0]);
                reject_d   = 1'b0;
            end else begin
                reject_d   = 1'b1;
            end
        end else begin
            balance_d = balance_q;
        end
    end

    // State registers; reset has priority over any press, price echo tracks the switches regardless.
    always_ff @(posedge MAX10_CLK1_50) begin
        price_sel_q <= SW[5:4];
        if (rst_s) begin
            balance_q  <= 7'd0;
            coin_led_q <= 4'b0000;
            reject_q   <= 1'b0;
            insuf_q    <= 1'b0;
            vend_q     <= 1'b0;
        end else begin
            balance_q  <= balance_d;
            coin_led_q <= coin_led_d;
            reject_q   <= reject_d;
            insuf_q    <= insuf_d;
            vend_q     <= vend_d;
        end
    end

    assign balance_c = balance_q;
    assign LEDR      = {(balance_q == BAL_MAX), vend_q, insuf_q, reject_q, price_sel_q, coin_led_q};

endmodule

// File: tb/tb_maincontroller.sv
// Randomized bench for maincontroller against a transaction-level vending model.
module tb_maincontroller;

    logic       clk = 1'b0;
    logic [9:0] sw;
    logic [1:0] key;
    logic [6:0] bal_c;
    logic [9:0] ledr;

    int n_tests = 0;
    int n_fail  = 0;

    int         m_bal;
    logic [3:0] m_led;
    logic       m_rej, m_ins, m_vnd;

    always #5 clk = ~clk;

    maincontroller dut (
        .MAX10_CLK1_50 (clk),
        .SW            (sw),
        .KEY           (key),
        .balance_c     (bal_c),
        .LEDR          (ledr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coin_of(input logic [3:0] s);
        int vals [4] = '{1, 5, 10, 25};
        for (int i = 3; i >= 0; i--) if (s[i]) return vals[i];
        return 0;
    endfunction

    function automatic logic [3:0] onehot_of(input logic [3:0] s);
        for (int i = 3; i >= 0; i--) if (s[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    function automatic int price_of(input logic [1:0] s);
        int p;
        p = 25 * (int'(s) + 1);
        return (p > 99) ? 99 : p;
    endfunction

    task automatic model_reset();
        m_bal = 0; m_led = 4'b0000; m_rej = 1'b0; m_ins = 1'b0; m_vnd = 1'b0;
    endtask

    task automatic model_press(input logic [1:0] which);
        int c;
        int p;
        c = coin_of(sw[3:0]);
        p = price_of(sw[5:4]);
        if (which[1]) begin
            m_rej = 1'b0; m_ins = 1'b0; m_vnd = 1'b0;
            if (m_bal >= p) begin m_bal -= p; m_vnd = 1'b1; end
            else m_ins = 1'b1;
        end else if (which[0] && c != 0) begin
            m_rej = 1'b0; m_ins = 1'b0; m_vnd = 1'b0;
            if (m_bal + c <= 99) begin m_bal += c; m_led = onehot_of(sw[3:0]); end
            else m_rej = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "/bal"},  32'(bal_c),     32'(m_bal));
        check_eq({tag, "/coin"}, 32'(ledr[3:0]), 32'(m_led));
        check_eq({tag, "/psel"}, 32'(ledr[5:4]), 32'(sw[5:4]));
        check_eq({tag, "/rej"},  32'(ledr[6]),   32'(m_rej));
        check_eq({tag, "/ins"},  32'(ledr[7]),   32'(m_ins));
        check_eq({tag, "/vnd"},  32'(ledr[8]),   32'(m_vnd));
        check_eq({tag, "/full"}, 32'(ledr[9]),   32'(m_bal == 99));
    endtask

    task automatic set_sw(input logic [3:0] coin, input logic [1:0] sel);
        @(negedge clk);
        sw[3:0] = coin;
        sw[5:4] = sel;
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] which, input int hold);
        @(negedge clk);
        key = ~which;
        repeat (hold) @(negedge clk);
        key = 2'b11;
        repeat (4) @(negedge clk);
        model_press(which);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        sw[9] = 1'b1;
        repeat (n) @(negedge clk);
        sw[9] = 1'b0;
        model_reset();
    endtask

    initial begin
        sw  = 10'd0;
        key = 2'b11;
        model_reset();
        do_reset(3);
        check_all("reset");

        // Three pennies.
        set_sw(4'b0001, 2'b00);
        repeat (3) press(2'b01, 2);
        check_all("pennies");
        check_eq("pennies_bal", 32'(bal_c), 32'd3);

        // Build 90, overflow reject, then a nickel fits.
        do_reset(2);
        set_sw(4'b1000, 2'b00); repeat (3) press(2'b01, 1);
        set_sw(4'b0100, 2'b00); press(2'b01, 1);
        set_sw(4'b0010, 2'b00); press(2'b01, 1);
        check_eq("bal90", 32'(bal_c), 32'd90);
        set_sw(4'b1000, 2'b00); press(2'b01, 3);
        check_all("overflow");
        check_eq("overflow_rej", 32'(ledr[6]), 32'd1);
        set_sw(4'b0010, 2'b00); press(2'b01, 3);
        check_all("nickel95");
        check_eq("nickel95_bal", 32'(bal_c), 32'd95);

        // Vend from 30 at price 25, then insufficient.
        do_reset(1);
        set_sw(4'b1000, 2'b00); press(2'b01, 2);
        set_sw(4'b0010, 2'b00); press(2'b01, 2);
        press(2'b10, 2);
        check_all("vend_ok");
        check_eq("vend_ok_bal", 32'(bal_c), 32'd5);
        press(2'b10, 2);
        check_all("vend_insuf");

        // No-coin deposit changes nothing, flags hold.
        set_sw(4'b0000, 2'b00); press(2'b01, 2);
        check_all("nocoin");

        // Held button counts once.
        do_reset(1);
        set_sw(4'b0100, 2'b00); press(2'b01, 100);
        check_all("held");
        check_eq("held_bal", 32'(bal_c), 32'd10);

        // Simultaneous deposit and vend: vend only.
        do_reset(1);
        set_sw(4'b1000, 2'b00); press(2'b01, 2);
        press(2'b11, 2);
        check_all("simul");
        check_eq("simul_bal", 32'(bal_c), 32'd0);

        // Reach 99, then a one-clock reset.
        set_sw(4'b1000, 2'b11); repeat (3) press(2'b01, 1);
        set_sw(4'b0100, 2'b11); repeat (2) press(2'b01, 1);
        set_sw(4'b0001, 2'b11); repeat (4) press(2'b01, 1);
        check_all("full");
        check_eq("full_led", 32'(ledr[9]), 32'd1);
        do_reset(1);
        check_all("rst_mid");
        check_eq("rst_mid_flags", 32'(ledr[9:6]), 32'd0);

        // Button held through reset must not fire until re-pressed.
        @(negedge clk);
        sw[9] = 1'b1;
        key   = 2'b10;
        repeat (3) @(negedge clk);
        sw[9] = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        check_all("hold_thru_rst");
        key = 2'b11;
        repeat (5) @(negedge clk);
        check_all("hold_released");
        press(2'b01, 2);
        check_all("hold_repress");

        // Randomized operations against the model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            set_sw(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            press(2'($urandom_range(1, 3)), $urandom_range(1, 6));
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
